// File: rtl/tpu_ctrl_param_if.sv
// Operand-fetch / MMU-control bundle between the systolic sequencer and its environment.
// master = sequencer side, slave = memory/MMU side.
interface tpu_ctrl_param_if #(
  parameter int unsigned DIM    = 2,
  parameter int unsigned ADDR_W = $clog2(2 * DIM * DIM),
  parameter int unsigned IDX_W  = $clog2(DIM * DIM)
);
  logic              load_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mmu_en;
  logic [ADDR_W-1:0] mmu_cycle;
  logic              out_valid;
  logic [IDX_W-1:0]  out_idx;
  logic              done;
  logic [1:0]        state_out;

  modport master (
    input  load_en,
    output mem_addr,
    output mmu_en,
    output mmu_cycle,
    output out_valid,
    output out_idx,
    output done,
    output state_out
  );

  modport slave (
    output load_en,
    input  mem_addr,
    input  mmu_en,
    input  mmu_cycle,
    input  out_valid,
    input  out_idx,
    input  done,
    input  state_out
  );
endinterface

// File: rtl/tpu_ctrl_param.sv
// Sequencer for a DIM x DIM systolic MMU: fetches A/B operands, overlaps the next fetch with
// compute/writeback, drains to IDLE when the stream stops. TPU_CTRL_OVF_EN adds sticky ovf_err.
module tpu_ctrl_param #(
  parameter int unsigned DIM    = 2,
  parameter int unsigned N_ELEM = 2 * DIM * DIM,
  parameter int unsigned ADDR_W = $clog2(N_ELEM),
  parameter int unsigned IDX_W  = $clog2(DIM * DIM),
  parameter int unsigned LAT    = 3 * DIM - 2
) (
  input  logic             clk,
  input  logic             rst,
  tpu_ctrl_param_if.master bus
`ifdef TPU_CTRL_OVF_EN
  ,
  output logic             ovf_err
`endif
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StLoad    = 2'b01,
    StStream  = 2'b10,
    StIllegal = 2'b11
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_ELEM - 1);
  localparam logic [ADDR_W-1:0] WinLo    = ADDR_W'(LAT);
  localparam logic [ADDR_W-1:0] WinHi    = ADDR_W'(LAT + DIM * DIM - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cycle_q, cycle_d;
  logic              en_q, en_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic              batch_ok;
`ifdef TPU_CTRL_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cycle_d  = cycle_q;
    full_d   = full_q;
    done_d   = 1'b0;
    batch_ok = 1'b0;
`ifdef TPU_CTRL_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        cycle_d = '0;
        if (bus.load_en) begin
          addr_d  = ADDR_W'(1);
          state_d = StLoad;
        end
      end

      StLoad: begin
        if (bus.load_en) begin
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            cycle_d = '0;
            state_d = StStream;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      StStream: begin
        if (bus.load_en && !full_q) begin
          if (addr_q == LastAddr) begin
            full_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
`ifdef TPU_CTRL_OVF_EN
        if (bus.load_en && full_q) begin
          ovf_d = 1'b1;
        end
`endif
        if (cycle_q == LastAddr) begin
          // A load completing the batch on the wrap cycle still counts as a full batch.
          batch_ok = full_q || (bus.load_en && (addr_q == LastAddr));
          addr_d   = '0;
          full_d   = 1'b0;
          cycle_d  = '0;
          if (!batch_ok) begin
            state_d = StIdle;
            done_d  = 1'b1;
`ifdef TPU_CTRL_OVF_EN
            if ((addr_q != '0) || bus.load_en) begin
              ovf_d = 1'b1;
            end
`endif
          end
        end else begin
          cycle_d = cycle_q + ADDR_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
        addr_d  = '0;
        cycle_d = '0;
        full_d  = 1'b0;
      end
    endcase

    // Outputs are derived from next state so they are registered yet cycle-aligned.
    en_d    = (state_d == StStream);
    valid_d = en_d && (cycle_d >= WinLo) && (cycle_d <= WinHi);
    idx_d   = valid_d ? IDX_W'(cycle_d - WinLo) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cycle_q <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cycle_q <= cycle_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      full_q  <= full_d;
    end
  end

`ifdef TPU_CTRL_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_err = ovf_q;
`endif

  assign bus.mem_addr  = addr_q;
  assign bus.mmu_cycle = cycle_q;
  assign bus.mmu_en    = en_q;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.done      = done_q;
  assign bus.state_out = state_q;

endmodule
